// File: rtl/iicmb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iicmb_pkg
// Brief    : Register map, command opcodes, CMDR flags and transfer status
//            codes shared by the iicmb_m_wb Wishbone sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package iicmb_pkg;

  typedef enum logic [1:0] {
    REG_CSR  = 2'd0,
    REG_DPR  = 2'd1,
    REG_CMDR = 2'd2
  } reg_addr_t;

  localparam logic [7:0] c_cmd_write    = 8'h01;
  localparam logic [7:0] c_cmd_read_ack = 8'h02;
  localparam logic [7:0] c_cmd_read_nak = 8'h03;
  localparam logic [7:0] c_cmd_start    = 8'h04;
  localparam logic [7:0] c_cmd_stop     = 8'h05;
  localparam logic [7:0] c_cmd_set_bus  = 8'h06;

  localparam int c_cmdr_don = 7;
  localparam int c_cmdr_nak = 6;
  localparam int c_cmdr_al  = 5;
  localparam int c_cmdr_err = 4;

  localparam logic [7:0] c_csr_enable = 8'hC0;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_NACK     = 3'd1,
    ST_ARB_LOST = 3'd2,
    ST_ERR      = 3'd3,
    ST_TIMEOUT  = 3'd4,
    ST_BAD_BUS  = 3'd5
  } status_t;

endpackage
`default_nettype wire

// File: rtl/wb_master_port.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_port
// Brief    : Single-access Wishbone master; one transfer in flight, strobes
//            dropped the cycle after ack, done pulses once per access.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_port (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start,
  input  logic       we,
  input  logic [1:0] adr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  logic       r_cyc;
  logic       r_we;
  logic [1:0] r_adr;
  logic [7:0] r_dat;
  logic       r_done;
  logic [7:0] r_rdata;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= 2'd0;
      r_dat   <= 8'd0;
      r_done  <= 1'b0;
      r_rdata <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (r_cyc) begin
        if (ack_i) begin
          r_cyc  <= 1'b0;
          r_we   <= 1'b0;
          r_adr  <= 2'd0;
          r_dat  <= 8'd0;
          r_done <= 1'b1;
          if (!r_we) r_rdata <= dat_i;
        end
      end else if (start && !r_done) begin
        // The r_done guard keeps at least one idle cycle between strobes.
        r_cyc <= 1'b1;
        r_we  <= we;
        r_adr <= adr;
        r_dat <= wdata;
      end
    end
  end

  assign busy  = r_cyc;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign cyc_o = r_cyc;
  assign stb_o = r_cyc;
  assign we_o  = r_we;
  assign adr_o = r_adr;
  assign dat_o = r_dat;

endmodule
`default_nettype wire

// File: rtl/iicmb_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : iicmb_wb_sequencer
// Brief    : Wishbone master sequencing iicmb_m_wb register accesses for one
//            I2C transfer request at a time, with byte streams and status.
// Revision : 1.0 - initial release
// ============================================================================
module iicmb_wb_sequencer
  import iicmb_pkg::*;
#(
  parameter int NUM_I2C_BUSSES = 16,
  parameter int IRQ_TIMEOUT    = 2**20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_bus,
  input  logic [6:0] req_addr,
  input  logic       req_rnw,
  input  logic [7:0] req_len,
  input  logic       wdata_valid,
  output logic       wdata_ready,
  input  logic [7:0] wdata,
  output logic       rdata_valid,
  input  logic       rdata_ready,
  output logic [7:0] rdata,
  output logic       rdata_last,
  output logic       done,
  output logic [2:0] status,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       irq_i
);

  localparam int                 c_tmo_w    = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_load = c_tmo_w'(IRQ_TIMEOUT);
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
  localparam logic [31:0]        c_num_bus  = NUM_I2C_BUSSES;

  typedef enum logic [4:0] {
    S_IDLE, S_ENABLE, S_SEL_DPR, S_SEL_CMD, S_START, S_ADDR_DPR, S_ADDR_CMD,
    S_WR_WAIT, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_RD_HOLD, S_STOP,
    S_IRQ_WAIT, S_CMD_CHK, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  state_t             r_ret, w_ret_nxt;
  status_t            r_result, w_result_nxt;
  logic [2:0]         r_status;
  logic               r_sent;
  logic [3:0]         r_bus;
  logic [6:0]         r_addr;
  logic               r_rnw;
  logic [7:0]         r_cnt;
  logic [7:0]         r_wbyte;
  logic [3:0]         r_cur_bus;
  logic               r_cur_valid;
  logic               r_enabled;
  logic [c_tmo_w-1:0] r_tmo;
  logic [7:0]         r_rdata;
  logic               r_rdata_valid;
  logic               r_rdata_last;

  logic       w_access;
  logic       w_wb_start;
  logic       w_wb_we;
  logic [1:0] w_wb_adr;
  logic [7:0] w_wb_wdata;
  logic       w_wb_busy;
  logic       w_wb_done;
  logic [7:0] w_wb_rdata;
  logic       w_bad_bus;
  logic       w_timeout;
  logic       w_wdata_take;
  logic       w_rdata_take;
  logic       w_abort;

  assign w_bad_bus    = ({28'd0, req_bus} >= c_num_bus);
  assign w_timeout    = (r_state == S_IRQ_WAIT) && !irq_i && (r_tmo <= c_tmo_one);
  assign w_wdata_take = (r_state == S_WR_WAIT) && wdata_valid;
  assign w_rdata_take = (r_state == S_RD_HOLD) && rdata_ready;
  assign w_abort      = w_wb_rdata[c_cmdr_al] || w_wb_rdata[c_cmdr_err];
  assign w_wb_start   = w_access && !r_sent && !w_wb_busy;

  wb_master_port u_wb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .start (w_wb_start),
    .we    (w_wb_we),
    .adr   (w_wb_adr),
    .wdata (w_wb_wdata),
    .busy  (w_wb_busy),
    .done  (w_wb_done),
    .rdata (w_wb_rdata),
    .cyc_o (cyc_o),
    .stb_o (stb_o),
    .we_o  (we_o),
    .adr_o (adr_o),
    .dat_o (dat_o),
    .dat_i (dat_i),
    .ack_i (ack_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_ret    <= S_IDLE;
      r_result <= ST_OK;
    end else begin
      r_state  <= w_state_nxt;
      r_ret    <= w_ret_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Each access state issues one Wishbone access and advances on its done.
  always_comb begin
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret;
    w_result_nxt = r_result;
    w_access     = 1'b0;
    w_wb_we      = 1'b1;
    w_wb_adr     = REG_CMDR;
    w_wb_wdata   = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_result_nxt = ST_OK;
          if (w_bad_bus) begin
            w_result_nxt = ST_BAD_BUS;
            w_state_nxt  = S_DONE;
          end else if (!r_enabled) begin
            w_state_nxt = S_ENABLE;
          end else if (r_cur_valid && (req_bus == r_cur_bus)) begin
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_SEL_DPR;
          end
        end
      end
      S_ENABLE: begin
        w_access   = 1'b1;
        w_wb_adr   = REG_CSR;
        w_wb_wdata = c_csr_enable;
        if (w_wb_done) w_state_nxt = S_SEL_DPR;
      end
      S_SEL_DPR: begin
        w_access   = 1'b1;
        w_wb_adr   = REG_DPR;
        w_wb_wdata = {4'd0, r_bus};
        if (w_wb_done) w_state_nxt = S_SEL_CMD;
      end
      S_SEL_CMD: begin
        w_access   = 1'b1;
        w_wb_wdata = c_cmd_set_bus;
        if (w_wb_done) begin
          w_state_nxt = S_IRQ_WAIT;
          w_ret_nxt   = S_START;
        end
      end
      S_START: begin
        w_access   = 1'b1;
        w_wb_wdata = c_cmd_start;
        if (w_wb_done) begin
          w_state_nxt = S_IRQ_WAIT;
          w_ret_nxt   = S_ADDR_DPR;
        end
      end
      S_ADDR_DPR: begin
        w_access   = 1'b1;
        w_wb_adr   = REG_DPR;
        w_wb_wdata = {r_addr, r_rnw};
        if (w_wb_done) w_state_nxt = S_ADDR_CMD;
      end
      S_ADDR_CMD: begin
        w_access   = 1'b1;
        w_wb_wdata = c_cmd_write;
        if (w_wb_done) begin
          w_state_nxt = S_IRQ_WAIT;
          if (r_cnt == 8'd0)  w_ret_nxt = S_STOP;
          else if (r_rnw)     w_ret_nxt = S_RD_CMD;
          else                w_ret_nxt = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (wdata_valid) w_state_nxt = S_WR_DPR;
      end
      S_WR_DPR: begin
        w_access   = 1'b1;
        w_wb_adr   = REG_DPR;
        w_wb_wdata = r_wbyte;
        if (w_wb_done) w_state_nxt = S_WR_CMD;
      end
      S_WR_CMD: begin
        w_access   = 1'b1;
        w_wb_wdata = c_cmd_write;
        if (w_wb_done) begin
          w_state_nxt = S_IRQ_WAIT;
          w_ret_nxt   = (r_cnt == 8'd1) ? S_STOP : S_WR_WAIT;
        end
      end
      S_RD_CMD: begin
        w_access   = 1'b1;
        w_wb_wdata = (r_cnt == 8'd1) ? c_cmd_read_nak : c_cmd_read_ack;
        if (w_wb_done) begin
          w_state_nxt = S_IRQ_WAIT;
          w_ret_nxt   = S_RD_DPR;
        end
      end
      S_RD_DPR: begin
        w_access = 1'b1;
        w_wb_we  = 1'b0;
        w_wb_adr = REG_DPR;
        if (w_wb_done) w_state_nxt = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (rdata_ready) w_state_nxt = (r_cnt == 8'd1) ? S_STOP : S_RD_CMD;
      end
      S_STOP: begin
        w_access   = 1'b1;
        w_wb_wdata = c_cmd_stop;
        if (w_wb_done) begin
          w_state_nxt = S_IRQ_WAIT;
          w_ret_nxt   = S_DONE;
        end
      end
      S_IRQ_WAIT: begin
        if (irq_i) begin
          w_state_nxt = S_CMD_CHK;
        end else if (w_timeout) begin
          w_result_nxt = ST_TIMEOUT;
          w_state_nxt  = S_DONE;
        end
      end
      S_CMD_CHK: begin
        w_access = 1'b1;
        w_wb_we  = 1'b0;
        if (w_wb_done) begin
          // A NAK seen while already stopping keeps the earlier result.
          if (w_wb_rdata[c_cmdr_al]) begin
            w_result_nxt = ST_ARB_LOST;
            w_state_nxt  = S_DONE;
          end else if (w_wb_rdata[c_cmdr_err]) begin
            w_result_nxt = ST_ERR;
            w_state_nxt  = S_DONE;
          end else if (r_ret == S_DONE) begin
            w_state_nxt = S_DONE;
          end else if (w_wb_rdata[c_cmdr_nak]) begin
            w_result_nxt = ST_NACK;
            w_state_nxt  = S_STOP;
          end else if (w_wb_rdata[c_cmdr_don]) begin
            w_state_nxt = r_ret;
          end else begin
            w_result_nxt = ST_ERR;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_status      <= 3'd0;
      r_sent        <= 1'b0;
      r_bus         <= 4'd0;
      r_addr        <= 7'd0;
      r_rnw         <= 1'b0;
      r_cnt         <= 8'd0;
      r_wbyte       <= 8'd0;
      r_cur_bus     <= 4'd0;
      r_cur_valid   <= 1'b0;
      r_enabled     <= 1'b0;
      r_tmo         <= '0;
      r_rdata       <= 8'd0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
    end else begin
      if (w_wb_done)       r_sent <= 1'b0;
      else if (w_wb_start) r_sent <= 1'b1;

      if (r_state == S_IDLE && req_valid) begin
        r_bus  <= req_bus;
        r_addr <= req_addr;
        r_rnw  <= req_rnw;
        r_cnt  <= req_len;
      end

      if (r_state == S_ENABLE && w_wb_done) r_enabled <= 1'b1;
      if (r_state == S_SEL_CMD && w_wb_done) begin
        r_cur_bus   <= r_bus;
        r_cur_valid <= 1'b1;
      end
      if (r_state == S_CMD_CHK && w_wb_done && w_abort) r_cur_valid <= 1'b0;
      // A lost interrupt leaves the controller state unknown: force re-enable.
      if (w_timeout) begin
        r_enabled   <= 1'b0;
        r_cur_valid <= 1'b0;
      end

      if (w_wb_done && w_state_nxt == S_IRQ_WAIT) r_tmo <= c_tmo_load;
      else if (r_state == S_IRQ_WAIT && !irq_i)   r_tmo <= r_tmo - c_tmo_one;

      if (w_wdata_take) r_wbyte <= wdata;
      if ((r_state == S_WR_CMD && w_wb_done) || w_rdata_take) r_cnt <= r_cnt - 8'd1;

      if (r_state == S_RD_DPR && w_wb_done) begin
        r_rdata       <= w_wb_rdata;
        r_rdata_valid <= 1'b1;
        r_rdata_last  <= (r_cnt == 8'd1);
      end else if (w_rdata_take) begin
        r_rdata_valid <= 1'b0;
        r_rdata_last  <= 1'b0;
      end

      if (w_state_nxt == S_DONE && r_state != S_DONE) r_status <= w_result_nxt;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign wdata_ready = w_wdata_take;
  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign rdata_last  = r_rdata_last;
  assign done        = (r_state == S_DONE);
  assign status      = r_status;

endmodule
`default_nettype wire
